keyboard_voice_alloc: RTL and testbench
=======================================

// Module: keyboard_voice_alloc
// PURPOSE
// - Polyphonic successor to the single-key keyboard decoder.
// - Consumes a stream of 8-bit USB HID key press/release events and maps note keys to
//   {note, octave, flat}.
// - Allocates each note to one of NUM_VOICES voice slots, with oldest-voice stealing,
//   sustain and a timed release tail.
// - Also tracks instrument select and a global octave shift.
// - Sits between the USB keyboard event source and the per-voice waveform generators.
// PARAMETERS
// - NUM_VOICES   4        voice slots, 2..8
// - RELEASE_CYC  1024     cycles a voice stays audible after release; >=1
// - REL_W        $clog2(RELEASE_CYC+1)   release counter width (derived)
// PORTS
// - clk           in   1             system clock
// - reset         in   1             synchronous, active-high
// - key_valid     in   1             one key event this cycle
// - key_code      in   8             HID usage code of the event
// - key_up        in   1             1 = release, 0 = press; qualified by key_valid
// - sustain       in   1             sustain pedal level
// - instrument    out  1             0/1 instrument select
// - oct_shift     out  2             signed global shift, -1..+1
// - voice_active  out  NUM_VOICES    slot is sounding (HELD, SUSTAINED or RELEASING)
// - voice_gate    out  NUM_VOICES    slot key physically held (HELD only)
// - voice_note    out  3*NUM_VOICES  per-slot note, 1=C..7=B
// - voice_octave  out  3*NUM_VOICES  per-slot octave after shift, 1..4
// - voice_flat    out  NUM_VOICES    per-slot flat flag
// BEHAVIOUR
// - Reset: every slot IDLE; all voice outputs 0; instrument=0; oct_shift=0; age counters 0.
// - All outputs are registered. A qualified event is visible on the outputs 1 cycle later.
//   At most one event per cycle.
// - Control keys (press only; releases ignored):
//   - 0x3A: instrument=0.
//   - 0x3B: instrument=1.
//   - 0x3C: oct_shift-- , saturating at -1.
//   - 0x3D: oct_shift++ , saturating at +1.
// - Note keys: mapped by pkg function hid_to_note (37-key layout, octaves 1-3 plus C4).
//   Examples: 0x1D->C1, 0x16->Db1, 0x06->E1, 0x14->F2, 0x30->C4.
//   Unmapped codes are ignored.
// - Stored octave = base + oct_shift, clamped to 1..4; latched at press time.
// - Per-slot FSM:
//   - IDLE -press alloc-> HELD.
//   - HELD -up & !sustain-> RELEASING.
//   - HELD -up & sustain-> SUSTAINED.
//   - SUSTAINED -sustain falls-> RELEASING.
//   - RELEASING -counter reaches RELEASE_CYC-> IDLE.
// - Each slot stores its key_code so a release can be matched to it.
// - Press allocation:
//   - Key already in HELD or SUSTAINED in some slot: no new slot. A SUSTAINED slot returns
//     to HELD.
//   - Else choose the lowest-index IDLE slot.
//   - Else the lowest-index RELEASING slot with the largest age.
//   - Else (all HELD/SUSTAINED) the slot with the largest age, lowest index on tie; it is
//     stolen.
//   - A stolen or retriggered slot restarts in HELD with age 0.
// - Age: on each allocation, every other active slot's age increments, saturating at
//   NUM_VOICES-1. IDLE slots hold age 0.
// - Release: key_up matching a HELD slot's code. Non-matching releases are ignored.
// - Release counter clears on entry to RELEASING. A re-press of the same code while
//   RELEASING is a new allocation.
// - Simultaneous events:
//   - A counter expiry in the same cycle as an allocation: the expiring slot counts as
//     RELEASING for selection, so it is not double-used.
//   - A sustain fall in the same cycle as a key_up: the released slot goes straight to
//     RELEASING.
// - Reset mid-operation: all slots IDLE in the next cycle; any pending event is dropped.
// STRUCTURE
// - Package keyboard_pkg:
//   - typedef enum voice_state_t {IDLE, HELD, SUSTAINED, RELEASING}.
//   - struct note_t {note[2:0], octave[2:0], flat}.
//   - HID constants for the control keys.
//   - Function hid_to_note returning {valid, note_t}.
// - Sub-module voice_slot: one instance per voice, generated. It holds the state, code,
//   note_t, age and release counter.
// - The top level holds the allocator priority logic and the instrument/shift registers.
// TESTING
// - Press 0x1D -> next cycle slot0 active+gate, note=1, oct=1, flat=0.
//   Release -> gate=0, active stays for 1024 cycles, then 0.
// - 0x3D then 0x06 -> slot0 note=3, oct=2. Press 0x3D twice more: oct_shift stays +1.
// - Press 5 distinct note keys (NUM_VOICES=4) -> 5th takes slot0 (oldest), code/note
//   updated, slots1-3 unchanged.
// - sustain=1, press/release 0x16 -> active=1, gate=0 (SUSTAINED).
//   sustain=0 -> RELEASING; expires after RELEASE_CYC.
// - Press 0x1D twice with no release -> only slot0 used.
//   Release of unheld 0x30 -> no change. Codes 0x00/0xFF -> ignored.
// - Assert reset with 3 slots active -> next cycle all outputs 0, instrument=0, oct_shift=0.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared types and helpers for the polyphonic keyboard voice allocator:
// voice slot states, the packed note descriptor and the HID key map.
package keyboard_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        SUSTAINED = 2'd2,
        RELEASING = 2'd3
    } voice_state_t;

    // note: 1=C .. 7=B; flat marks the black key just below that note.
    typedef struct packed {
        logic [2:0] note;
        logic [2:0] octave;
        logic       flat;
    } note_t;

    typedef struct packed {
        logic  valid;
        note_t nt;
    } note_lookup_t;

    // Control keys (F1..F4), acted on at press only.
    localparam logic [7:0] HID_INSTR0   = 8'h3A;
    localparam logic [7:0] HID_INSTR1   = 8'h3B;
    localparam logic [7:0] HID_OCT_DOWN = 8'h3C;
    localparam logic [7:0] HID_OCT_UP   = 8'h3D;

    // Age counters only need to rank up to 8 voices.
    localparam int AGE_W = 3;

    function automatic note_lookup_t mk_note(input logic [2:0] n, input logic f,
                                             input logic [2:0] o);
        return {1'b1, n, o, f};
    endfunction

    // 37-key layout: Z-row + home row = octave 1, ",./;L" + Q-row/digits = octave 2
    // (continuing from F2 on Q), T..] = octave 3 plus C4 on ']'.
    function automatic note_lookup_t hid_to_note(input logic [7:0] code);
        note_lookup_t r;
        case (code)
            8'h1D: r = mk_note(3'd1, 1'b0, 3'd1);
            8'h16: r = mk_note(3'd2, 1'b1, 3'd1);
            8'h1B: r = mk_note(3'd2, 1'b0, 3'd1);
            8'h07: r = mk_note(3'd3, 1'b1, 3'd1);
            8'h06: r = mk_note(3'd3, 1'b0, 3'd1);
            8'h19: r = mk_note(3'd4, 1'b0, 3'd1);
            8'h0A: r = mk_note(3'd5, 1'b1, 3'd1);
            8'h05: r = mk_note(3'd5, 1'b0, 3'd1);
            8'h0B: r = mk_note(3'd6, 1'b1, 3'd1);
            8'h11: r = mk_note(3'd6, 1'b0, 3'd1);
            8'h0D: r = mk_note(3'd7, 1'b1, 3'd1);
            8'h10: r = mk_note(3'd7, 1'b0, 3'd1);
            8'h36: r = mk_note(3'd1, 1'b0, 3'd2);
            8'h0F: r = mk_note(3'd2, 1'b1, 3'd2);
            8'h37: r = mk_note(3'd2, 1'b0, 3'd2);
            8'h33: r = mk_note(3'd3, 1'b1, 3'd2);
            8'h38: r = mk_note(3'd3, 1'b0, 3'd2);
            8'h14: r = mk_note(3'd4, 1'b0, 3'd2);
            8'h1F: r = mk_note(3'd5, 1'b1, 3'd2);
            8'h1A: r = mk_note(3'd5, 1'b0, 3'd2);
            8'h20: r = mk_note(3'd6, 1'b1, 3'd2);
            8'h08: r = mk_note(3'd6, 1'b0, 3'd2);
            8'h21: r = mk_note(3'd7, 1'b1, 3'd2);
            8'h15: r = mk_note(3'd7, 1'b0, 3'd2);
            8'h17: r = mk_note(3'd1, 1'b0, 3'd3);
            8'h23: r = mk_note(3'd2, 1'b1, 3'd3);
            8'h1C: r = mk_note(3'd2, 1'b0, 3'd3);
            8'h24: r = mk_note(3'd3, 1'b1, 3'd3);
            8'h18: r = mk_note(3'd3, 1'b0, 3'd3);
            8'h0C: r = mk_note(3'd4, 1'b0, 3'd3);
            8'h26: r = mk_note(3'd5, 1'b1, 3'd3);
            8'h12: r = mk_note(3'd5, 1'b0, 3'd3);
            8'h27: r = mk_note(3'd6, 1'b1, 3'd3);
            8'h13: r = mk_note(3'd6, 1'b0, 3'd3);
            8'h2D: r = mk_note(3'd7, 1'b1, 3'd3);
            8'h2F: r = mk_note(3'd7, 1'b0, 3'd3);
            8'h30: r = mk_note(3'd1, 1'b0, 3'd4);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Base octave plus signed shift (-1..+1), clamped to 1..4.
    function automatic logic [2:0] shift_octave(input logic [2:0] base,
                                                input logic [1:0] shift);
        logic [3:0] sum;
        sum = {1'b0, base} + {{2{shift[1]}}, shift};
        if (sum == 4'd0)      return 3'd1;
        else if (sum > 4'd4)  return 3'd4;
        else                  return sum[2:0];
    endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice slot: lifecycle FSM, stored key code / note, age rank and the
// release-tail counter. The allocator in the top level decides when to load it.
module voice_slot
    import keyboard_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int RELEASE_CYC = 1024,
    parameter int REL_W       = $clog2(RELEASE_CYC + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_alloc,
    input  logic               i_age_inc,
    input  logic               i_key_up,
    input  logic               i_sustain,
    input  logic [7:0]         i_code,
    input  note_t              i_note,
    output voice_state_t       o_state,
    output logic [7:0]         o_code,
    output note_t              o_note,
    output logic [AGE_W-1:0]   o_age
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYC - 1);

    voice_state_t     r_state;
    logic [7:0]       r_code;
    note_t            r_note;
    logic [AGE_W-1:0] r_age;
    logic [REL_W-1:0] r_rel_cnt;

    logic w_rel_hit;

    // Only a physically held key can be released; sustained slots ignore key-ups.
    assign w_rel_hit = i_key_up && (r_state == HELD) && (r_code == i_code);

    // Slot FSM: a load wins over everything, including a same-cycle expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_code    <= '0;
            r_note    <= '0;
            r_age     <= '0;
            r_rel_cnt <= '0;
        end else if (i_alloc) begin
            r_state   <= HELD;
            r_code    <= i_code;
            r_note    <= i_note;
            r_age     <= '0;
            r_rel_cnt <= '0;
        end else begin
            if (i_age_inc && (r_state != IDLE) && (r_age != AGE_MAX))
                r_age <= r_age + 1'b1;
            case (r_state)
                HELD: begin
                    if (w_rel_hit) begin
                        // Sustain low here also covers a pedal release in the same cycle.
                        r_state   <= i_sustain ? SUSTAINED : RELEASING;
                        r_rel_cnt <= '0;
                    end
                end
                SUSTAINED: begin
                    if (!i_sustain) begin
                        r_state   <= RELEASING;
                        r_rel_cnt <= '0;
                    end
                end
                RELEASING: begin
                    if (r_rel_cnt == REL_LAST) begin
                        r_state   <= IDLE;
                        r_code    <= '0;
                        r_note    <= '0;
                        r_age     <= '0;
                        r_rel_cnt <= '0;
                    end else begin
                        r_rel_cnt <= r_rel_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_code  = r_code;
    assign o_note  = r_note;
    assign o_age   = r_age;

endmodule

// File: rtl/keyboard_voice_alloc.sv
// Polyphonic keyboard front end: decodes HID key events, keeps the instrument
// and octave-shift registers and assigns note presses to voice slots.
module keyboard_voice_alloc
    import keyboard_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int RELEASE_CYC = 1024,
    parameter int REL_W       = $clog2(RELEASE_CYC + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      key_valid,
    input  logic [7:0]                key_code,
    input  logic                      key_up,
    input  logic                      sustain,
    output logic                      instrument,
    output logic [1:0]                oct_shift,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [3*NUM_VOICES-1:0]   voice_note,
    output logic [3*NUM_VOICES-1:0]   voice_octave,
    output logic [NUM_VOICES-1:0]     voice_flat
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    logic              r_instrument;
    logic [1:0]        r_oct_shift;

    voice_state_t      w_state [NUM_VOICES];
    logic [7:0]        w_code  [NUM_VOICES];
    note_t             w_vnote [NUM_VOICES];
    logic [AGE_W-1:0]  w_age   [NUM_VOICES];

    note_lookup_t      w_lookup;
    note_t             w_new_note;
    logic              w_press;
    logic              w_up;
    logic              w_note_press;

    logic              w_hit_found;
    logic [IDX_W-1:0]  w_hit_idx;
    logic              w_idle_found;
    logic [IDX_W-1:0]  w_idle_idx;
    logic              w_rel_found;
    logic [IDX_W-1:0]  w_rel_idx;
    logic [AGE_W-1:0]  w_rel_age;
    logic [IDX_W-1:0]  w_steal_idx;
    logic [AGE_W-1:0]  w_steal_age;
    logic [IDX_W-1:0]  w_target;

    assign w_press      = key_valid && !key_up;
    assign w_up         = key_valid && key_up;
    assign w_lookup     = hid_to_note(key_code);
    assign w_note_press = w_press && w_lookup.valid;

    // Octave is frozen at press time using the shift in force before this event.
    always_comb begin
        w_new_note        = w_lookup.nt;
        w_new_note.octave = shift_octave(w_lookup.nt.octave, r_oct_shift);
    end

    // Slot selection: retrigger of a held/sustained key, else first idle slot,
    // else oldest releasing slot, else steal the oldest sounding slot.
    always_comb begin
        w_hit_found  = 1'b0;
        w_hit_idx    = '0;
        w_idle_found = 1'b0;
        w_idle_idx   = '0;
        w_rel_found  = 1'b0;
        w_rel_idx    = '0;
        w_rel_age    = '0;
        w_steal_idx  = '0;
        w_steal_age  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_hit_found && ((w_state[i] == HELD) || (w_state[i] == SUSTAINED))
                && (w_code[i] == key_code)) begin
                w_hit_found = 1'b1;
                w_hit_idx   = IDX_W'(i);
            end
            if (!w_idle_found && (w_state[i] == IDLE)) begin
                w_idle_found = 1'b1;
                w_idle_idx   = IDX_W'(i);
            end
            // Strict compare keeps the lowest index on an age tie.
            if ((w_state[i] == RELEASING) && (!w_rel_found || (w_age[i] > w_rel_age))) begin
                w_rel_found = 1'b1;
                w_rel_idx   = IDX_W'(i);
                w_rel_age   = w_age[i];
            end
            if ((i == 0) || (w_age[i] > w_steal_age)) begin
                w_steal_idx = IDX_W'(i);
                w_steal_age = w_age[i];
            end
        end
        if (w_hit_found)       w_target = w_hit_idx;
        else if (w_idle_found) w_target = w_idle_idx;
        else if (w_rel_found)  w_target = w_rel_idx;
        else                   w_target = w_steal_idx;
    end

    // Instrument select and saturating global octave shift (press only).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instrument <= 1'b0;
            r_oct_shift  <= 2'b00;
        end else if (w_press) begin
            case (key_code)
                HID_INSTR0:   r_instrument <= 1'b0;
                HID_INSTR1:   r_instrument <= 1'b1;
                HID_OCT_DOWN: if (r_oct_shift != 2'b11) r_oct_shift <= r_oct_shift - 1'b1;
                HID_OCT_UP:   if (r_oct_shift != 2'b01) r_oct_shift <= r_oct_shift + 1'b1;
                default: ;
            endcase
        end
    end

    assign instrument = r_instrument;
    assign oct_shift  = r_oct_shift;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        logic w_alloc;
        logic w_age_inc;

        assign w_alloc   = w_note_press && (w_target == IDX_W'(g));
        assign w_age_inc = w_note_press && (w_target != IDX_W'(g));

        voice_slot #(
            .NUM_VOICES  (NUM_VOICES),
            .RELEASE_CYC (RELEASE_CYC),
            .REL_W       (REL_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .i_alloc   (w_alloc),
            .i_age_inc (w_age_inc),
            .i_key_up  (w_up),
            .i_sustain (sustain),
            .i_code    (key_code),
            .i_note    (w_new_note),
            .o_state   (w_state[g]),
            .o_code    (w_code[g]),
            .o_note    (w_vnote[g]),
            .o_age     (w_age[g])
        );

        assign voice_active[g]       = (w_state[g] != IDLE);
        assign voice_gate[g]         = (w_state[g] == HELD);
        assign voice_note[3*g +: 3]   = w_vnote[g].note;
        assign voice_octave[3*g +: 3] = w_vnote[g].octave;
        assign voice_flat[g]         = w_vnote[g].flat;
    end

endmodule

// File: tb/tb_keyboard_voice_alloc.sv
// Directed bench for keyboard_voice_alloc: single-note lifecycle, octave shift,
// voice stealing, sustain, duplicate/unmapped keys and mid-run reset.
module tb_keyboard_voice_alloc;

  localparam int NV  = 4;
  localparam int REL = 1024;

  logic          clk;
  logic          reset;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          key_up;
  logic          sustain;
  logic          instrument;
  logic [1:0]    oct_shift;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] voice_gate;
  logic [3*NV-1:0] voice_note;
  logic [3*NV-1:0] voice_octave;
  logic [NV-1:0] voice_flat;

  int checks;
  int failures;

  keyboard_voice_alloc #(
    .NUM_VOICES  (NV),
    .RELEASE_CYC (REL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_up       (key_up),
    .sustain      (sustain),
    .instrument   (instrument),
    .oct_shift    (oct_shift),
    .voice_active (voice_active),
    .voice_gate   (voice_gate),
    .voice_note   (voice_note),
    .voice_octave (voice_octave),
    .voice_flat   (voice_flat)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one event, applied for exactly one rising edge; returns on the following negedge
  task automatic key_event(input logic [7:0] code, input logic up);
    key_valid = 1'b1;
    key_code  = code;
    key_up    = up;
    @(negedge clk);
    key_valid = 1'b0;
    key_up    = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic press(input logic [7:0] code);
    key_event(code, 1'b0);
  endtask

  task automatic release_key(input logic [7:0] code);
    key_event(code, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 8'h00;
    key_up    = 1'b0;
    sustain   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_active", voice_active, 0);
    check("rst_gate", voice_gate, 0);
    check("rst_note", voice_note, 0);
    check("rst_octave", voice_octave, 0);
    check("rst_flat", voice_flat, 0);
    check("rst_instr", instrument, 0);
    check("rst_shift", oct_shift, 0);

    // single note C1, release tail of exactly REL cycles
    press(8'h1D);
    check("c1_active", voice_active, 4'b0001);
    check("c1_gate", voice_gate, 4'b0001);
    check("c1_note", voice_note, 12'h001);
    check("c1_octave", voice_octave, 12'h001);
    check("c1_flat", voice_flat, 0);
    release_key(8'h1D);
    check("c1_rel_gate", voice_gate, 0);
    check("c1_rel_active", voice_active, 4'b0001);
    idle(REL - 1);
    check("c1_tail_last", voice_active, 4'b0001);
    idle(1);
    check("c1_tail_done", voice_active, 0);
    check("c1_idle_note", voice_note, 0);

    // octave shift up, E1 -> octave 2, saturation at both ends
    press(8'h3D);
    check("shift_up", oct_shift, 2'b01);
    press(8'h06);
    check("e1_note", voice_note, 12'h003);
    check("e1_octave", voice_octave, 12'h002);
    press(8'h3D);
    press(8'h3D);
    check("shift_sat_hi", oct_shift, 2'b01);
    press(8'h3C);
    check("shift_zero", oct_shift, 2'b00);
    press(8'h3C);
    check("shift_neg", oct_shift, 2'b11);
    press(8'h3C);
    check("shift_sat_lo", oct_shift, 2'b11);
    press(8'h1D);
    check("clamp_lo_oct", voice_octave[5:3], 3'd1);
    check("clamp_lo_active", voice_active, 4'b0011);
    press(8'h3B);
    check("instr1", instrument, 1'b1);
    release_key(8'h3A);
    check("instr_up_ignored", instrument, 1'b1);
    press(8'h3A);
    check("instr0", instrument, 1'b0);

    // fill all four voices, then steal the oldest
    do_reset();
    press(8'h1D);
    press(8'h1B);
    press(8'h06);
    press(8'h19);
    check("fill_active", voice_active, 4'b1111);
    check("fill_note", voice_note, {3'd4, 3'd3, 3'd2, 3'd1});
    press(8'h05);
    check("steal_note", voice_note, {3'd4, 3'd3, 3'd2, 3'd5});
    check("steal_gate", voice_gate, 4'b1111);
    release_key(8'h1D);
    check("stolen_code_gone", voice_gate, 4'b1111);
    release_key(8'h05);
    check("new_code_release", voice_gate, 4'b1110);
    check("new_code_active", voice_active, 4'b1111);
    // slot0 is releasing: it is preferred over the oldest held slot1
    press(8'h0A);
    check("rel_pref_note", voice_note, {3'd4, 3'd3, 3'd2, 3'd5});
    check("rel_pref_flat", voice_flat, 4'b0001);
    check("rel_pref_gate", voice_gate, 4'b1111);

    // sustain pedal
    do_reset();
    sustain = 1'b1;
    press(8'h16);
    check("db1_note", voice_note, 12'h002);
    check("db1_flat", voice_flat, 4'b0001);
    release_key(8'h16);
    check("sus_active", voice_active, 4'b0001);
    check("sus_gate", voice_gate, 0);
    idle(1500);
    check("sus_hold", voice_active, 4'b0001);
    sustain = 1'b0;
    @(negedge clk);
    check("sus_fall_active", voice_active, 4'b0001);
    idle(REL - 1);
    check("sus_tail_last", voice_active, 4'b0001);
    idle(1);
    check("sus_tail_done", voice_active, 0);
    // re-press of a sustained key returns the same slot to held
    sustain = 1'b1;
    press(8'h1D);
    release_key(8'h1D);
    press(8'h1D);
    check("sus_retrig_gate", voice_gate, 4'b0001);
    check("sus_retrig_active", voice_active, 4'b0001);
    sustain = 1'b0;

    // duplicate presses, unheld release, unmapped codes
    do_reset();
    press(8'h1D);
    press(8'h1D);
    check("dup_active", voice_active, 4'b0001);
    release_key(8'h30);
    check("unheld_rel_gate", voice_gate, 4'b0001);
    press(8'h00);
    press(8'hFF);
    check("unmapped_active", voice_active, 4'b0001);
    check("unmapped_note", voice_note, 12'h001);

    // C4 with +1 shift clamps to octave 4; F2 with +1 lands on octave 3
    press(8'h3B);
    press(8'h3D);
    press(8'h30);
    check("c4_note", voice_note[5:3], 3'd1);
    check("c4_octave", voice_octave[5:3], 3'd4);
    press(8'h14);
    check("f2_note", voice_note[8:6], 3'd4);
    check("f2_octave", voice_octave[8:6], 3'd3);
    check("three_active", voice_active, 4'b0111);

    // reset with a pending press: everything clears, the event is dropped
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 8'h1B;
    key_up    = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    key_valid = 1'b0;
    check("mid_rst_active", voice_active, 0);
    check("mid_rst_gate", voice_gate, 0);
    check("mid_rst_note", voice_note, 0);
    check("mid_rst_octave", voice_octave, 0);
    check("mid_rst_instr", instrument, 0);
    check("mid_rst_shift", oct_shift, 0);
    @(negedge clk);
    check("mid_rst_dropped", voice_active, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
